// File: rtl/ltf_pkg.sv
// Shared constants for the obfuscated-LTF receive path: state encoding,
// per-carrier attenuation codes and the LTF sign table indexed by FFT bin.
package ltf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SYM1,
    ST_SYM2
  } state_e;

  typedef enum logic [1:0] {
    COEF_X1   = 2'b00,
    COEF_DIV8 = 2'b01,
    COEF_DIV2 = 2'b10,
    COEF_DIV4 = 2'b11
  } coef_e;

  localparam logic [1:0] SGN_NULL = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b11;

  // Bins 1..26 carry L(+1..+26), bins 38..63 carry L(-26..-1); DC and guard bins are null.
  localparam logic [1:0] LTF_SIGN [0:63] = '{
    SGN_NULL, SGN_POS,  SGN_NEG,  SGN_NEG,  SGN_POS,  SGN_POS,  SGN_NEG,  SGN_POS,
    SGN_NEG,  SGN_POS,  SGN_NEG,  SGN_NEG,  SGN_NEG,  SGN_NEG,  SGN_NEG,  SGN_POS,
    SGN_POS,  SGN_NEG,  SGN_NEG,  SGN_POS,  SGN_NEG,  SGN_POS,  SGN_NEG,  SGN_POS,
    SGN_POS,  SGN_POS,  SGN_POS,  SGN_NULL, SGN_NULL, SGN_NULL, SGN_NULL, SGN_NULL,
    SGN_NULL, SGN_NULL, SGN_NULL, SGN_NULL, SGN_NULL, SGN_NULL, SGN_POS,  SGN_POS,
    SGN_NEG,  SGN_NEG,  SGN_POS,  SGN_POS,  SGN_NEG,  SGN_POS,  SGN_NEG,  SGN_POS,
    SGN_POS,  SGN_POS,  SGN_POS,  SGN_POS,  SGN_POS,  SGN_NEG,  SGN_NEG,  SGN_POS,
    SGN_POS,  SGN_NEG,  SGN_POS,  SGN_NEG,  SGN_POS,  SGN_POS,  SGN_POS,  SGN_POS
  };

endpackage

// File: rtl/ltf_carrier_scaler.sv
// One real-valued component: undo the TX attenuation by a left shift,
// saturate back to DW bits, then apply the known LTF sign of the carrier.
module ltf_carrier_scaler
  import ltf_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] avg,
  input  logic [1:0]    coef,
  input  logic [1:0]    ltf_sign,
  output logic [DW-1:0] result
);

  localparam int SW = DW + 4;
  localparam logic signed [SW-1:0] WIDE_MAX = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] WIDE_MIN = SW'(-(2 ** (DW - 1)));
  localparam logic [DW-1:0] NARROW_MAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] NARROW_MIN = {1'b1, {(DW - 1){1'b0}}};

  logic signed [SW-1:0] wide;
  logic signed [SW-1:0] scaled;
  logic [DW-1:0]        sat;

  always_comb begin
    wide = {{4{avg[DW-1]}}, avg};
    case (coef)
      COEF_DIV8: scaled = wide <<< 3;
      COEF_DIV2: scaled = wide <<< 1;
      COEF_DIV4: scaled = wide <<< 2;
      default:   scaled = wide;
    endcase

    if (scaled > WIDE_MAX) begin
      sat = NARROW_MAX;
    end else if (scaled < WIDE_MIN) begin
      sat = NARROW_MIN;
    end else begin
      sat = scaled[DW-1:0];
    end

    // Negating the most negative value would wrap, so it clips to the positive limit.
    case (ltf_sign)
      SGN_POS: result = sat;
      SGN_NEG: result = (sat == NARROW_MIN) ? NARROW_MAX : (~sat + 1'b1);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ltf_deobfuscator.sv
// Averages the two received LTF symbols per bin, removes the obfuscation
// attenuation and the LTF sign, and streams one channel estimate per bin.
module ltf_deobfuscator
  import ltf_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NFFT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*NFFT-1:0]       coefficients,
  input  logic [2*DW-1:0]         fft_data,
  input  logic                    fft_valid,
  input  logic                    fft_first,
  output logic [2*DW-1:0]         chan_data,
  output logic                    chan_valid,
  output logic [$clog2(NFFT)-1:0] chan_idx,
  output logic                    chan_last,
  output logic                    busy,
  output logic                    resync
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_BIN = AW'(NFFT - 1);

  state_e          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [2*NFFT-1:0] coef_reg;
  logic            resync_reg, resync_next;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic            launch;
  logic            flush;

  logic [2*DW-1:0] mem [NFFT];
  logic [2*DW-1:0] rd_data_reg;

  logic            s1_valid_reg;
  logic [AW-1:0]   s1_idx_reg;
  logic [2*DW-1:0] s1_sample_reg;
  logic [DW-1:0]   res_c [2];

  assign busy   = (state_reg != ST_IDLE);
  assign resync = resync_reg;

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    resync_next = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = idx_reg;
    launch      = 1'b0;
    flush       = 1'b0;

    if (start) begin
      state_next = ST_ARMED;
      idx_next   = '0;
      flush      = (state_reg != ST_IDLE);
    end else if (fft_valid) begin
      case (state_reg)
        ST_ARMED: begin
          if (fft_first) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            state_next = ST_SYM1;
            idx_next   = AW'(1);
          end
        end
        ST_SYM1, ST_SYM2: begin
          // A misplaced symbol marker restarts collection with this sample as bin 0.
          if (fft_first && (idx_reg != '0)) begin
            resync_next = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = '0;
            state_next  = ST_SYM1;
            idx_next    = AW'(1);
          end else if (state_reg == ST_SYM1) begin
            wr_en    = 1'b1;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == LAST_BIN) state_next = ST_SYM2;
          end else begin
            launch   = 1'b1;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == LAST_BIN) state_next = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // First-symbol buffer; the read is registered so it lines up with stage 1.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= fft_data;
    rd_data_reg <= mem[idx_reg];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic [DW-1:0] a_c;
      logic [DW-1:0] b_c;
      logic [DW:0]   sum_c;

      assign a_c   = s1_sample_reg[gi*DW +: DW];
      assign b_c   = rd_data_reg[gi*DW +: DW];
      assign sum_c = {a_c[DW-1], a_c} + {b_c[DW-1], b_c};

      ltf_carrier_scaler #(
        .DW(DW)
      ) u_scaler (
        .avg     (sum_c[DW:1]),
        .coef    (coef_reg[{s1_idx_reg, 1'b0} +: 2]),
        .ltf_sign(LTF_SIGN[s1_idx_reg]),
        .result  (res_c[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      coef_reg      <= '0;
      resync_reg    <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_idx_reg    <= '0;
      s1_sample_reg <= '0;
      chan_data     <= '0;
      chan_valid    <= 1'b0;
      chan_idx      <= '0;
      chan_last     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      resync_reg   <= resync_next;
      if (start) coef_reg <= coefficients;

      s1_valid_reg <= launch;
      if (launch) begin
        s1_idx_reg    <= idx_reg;
        s1_sample_reg <= fft_data;
      end

      chan_valid <= s1_valid_reg && !flush;
      chan_last  <= s1_valid_reg && !flush && (s1_idx_reg == LAST_BIN);
      if (s1_valid_reg && !flush) begin
        chan_data <= {res_c[1], res_c[0]};
        chan_idx  <= s1_idx_reg;
      end
    end
  end

endmodule

// File: tb/tb_ltf_deobfuscator.sv
// Random and directed stimulus for ltf_deobfuscator against a cycle-indexed
// expectation table filled by a behavioural model of the receive rules.
module tb_ltf_deobfuscator;

  logic         clk = 1'b0;
  logic         reset, start, fft_valid, fft_first;
  logic [127:0] coefficients;
  logic [31:0]  fft_data;
  logic [31:0]  chan_data;
  logic         chan_valid;
  logic [5:0]   chan_idx;
  logic         chan_last, busy, resync;

  always #5 clk = ~clk;

  ltf_deobfuscator #(.DW(16), .NFFT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .coefficients(coefficients),
    .fft_data    (fft_data),
    .fft_valid   (fft_valid),
    .fft_first   (fft_first),
    .chan_data   (chan_data),
    .chan_valid  (chan_valid),
    .chan_idx    (chan_idx),
    .chan_last   (chan_last),
    .busy        (busy),
    .resync      (resync)
  );

  localparam int MAXC = 40000;
  bit          exp_valid  [MAXC];
  logic [31:0] exp_data   [MAXC];
  int          exp_idx    [MAXC];
  bit          exp_busy   [MAXC];
  bit          exp_resync [MAXC];
  bit          exp_zero   [MAXC];

  int  n_edge = 0;
  bit  checking = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  out_count = 0;
  int  resync_seen = 0;
  int  ck;
  logic [31:0] got [64];

  // Model state: 0 idle, 1 armed, 2 collecting first symbol, 3 combining second symbol
  int          m_mode = 0;
  int          m_pos = 0;
  logic [31:0] m_buf [64];
  logic [127:0] m_coef = '0;

  int lpos [26] = '{1,-1,-1,1,1,-1,1,-1,1,-1,-1,-1,-1,-1,1,1,-1,-1,1,-1,1,-1,1,1,1,1};
  int lneg [26] = '{1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,1,1,-1,-1,1,1,-1,1,-1,1,1,1,1};

  logic [31:0] sym_a [64];
  logic [31:0] sym_b [64];

  always @(posedge clk) n_edge <= n_edge + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, n_edge, act, exp);
    end
  endtask

  function automatic int ltf_sign(int k);
    if (k >= 1 && k <= 26) return lpos[k-1];
    if (k >= 38 && k <= 63) return lneg[k-38];
    return 0;
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] comp(int a, int b, int mult, int s);
    int sum, avg, v;
    sum = a + b;
    avg = (sum >= 0) ? sum / 2 : -((1 - sum) / 2);
    v = clamp16(avg * mult);
    v = clamp16(v * s);
    return v[15:0];
  endfunction

  function automatic logic [31:0] expect_word(logic [31:0] x, logic [31:0] y, int k, logic [1:0] c);
    int mult, s;
    mult = (c == 2'd0) ? 1 : (c == 2'd1) ? 8 : (c == 2'd2) ? 2 : 4;
    s = ltf_sign(k);
    return {comp(int'($signed(x[31:16])), int'($signed(y[31:16])), mult, s),
            comp(int'($signed(x[15:0])),  int'($signed(y[15:0])),  mult, s)};
  endfunction

  function automatic logic [127:0] rc();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one cycle of inputs and record what the block must show after that edge.
  task automatic step(bit r, bit s, bit v, bit f, logic [31:0] d, logic [127:0] c);
    int t;
    reset = r; start = s; fft_valid = v; fft_first = f; fft_data = d; coefficients = c;
    t = n_edge + 1;
    if (t + 2 >= MAXC) begin
      $display("FAIL cycle_budget: got edge %0d, expected below %0d", t, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    exp_resync[t] = 1'b0;
    exp_zero[t]   = 1'b0;
    if (r) begin
      m_mode = 0; m_pos = 0;
      exp_valid[t] = 1'b0;
      exp_zero[t]  = 1'b1;
    end else if (s) begin
      m_coef = c;
      if (m_mode != 0) exp_valid[t] = 1'b0;
      m_mode = 1; m_pos = 0;
    end else if (v) begin
      if (m_mode == 1) begin
        if (f) begin m_buf[0] = d; m_mode = 2; m_pos = 1; end
      end else if (m_mode >= 2 && f && m_pos != 0) begin
        exp_resync[t] = 1'b1;
        m_buf[0] = d; m_mode = 2; m_pos = 1;
      end else if (m_mode == 2) begin
        m_buf[m_pos] = d;
        m_pos++;
        if (m_pos == 64) begin m_mode = 3; m_pos = 0; end
      end else if (m_mode == 3) begin
        exp_valid[t+1] = 1'b1;
        exp_data[t+1]  = expect_word(d, m_buf[m_pos], m_pos, m_coef[2*m_pos +: 2]);
        exp_idx[t+1]   = m_pos;
        m_pos++;
        if (m_pos == 64) begin m_mode = 0; m_pos = 0; end
      end
    end
    exp_busy[t] = (m_mode != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(1), $urandom, rc());
  endtask

  task automatic run_pair(bit do_start, logic [127:0] c, int gap_pct);
    if (do_start) step(0, 1, 0, 0, 32'h0, c);
    for (int i = 0; i < 128; i++) begin
      while ($urandom_range(99) < gap_pct) step(0, 0, 0, $urandom_range(1), $urandom, rc());
      step(0, 0, 1, (i % 64) == 0, (i < 64) ? sym_a[i] : sym_b[i-64], rc());
    end
    idle(4);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      ck = n_edge;
      chk("chan_valid", {31'b0, chan_valid}, {31'b0, exp_valid[ck]});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy[ck]});
      chk("resync", {31'b0, resync}, {31'b0, exp_resync[ck]});
      if (exp_zero[ck]) begin
        chk("reset_data", chan_data, 32'h0);
        chk("reset_idx", {26'b0, chan_idx}, 32'h0);
        chk("reset_last", {31'b0, chan_last}, 32'h0);
      end
      if (exp_valid[ck] && chan_valid) begin
        chk("chan_data", chan_data, exp_data[ck]);
        chk("chan_idx", {26'b0, chan_idx}, 32'(exp_idx[ck]));
        chk("chan_last", {31'b0, chan_last}, {31'b0, exp_idx[ck] == 63});
      end
      if (chan_valid) begin
        got[chan_idx] = chan_data;
        out_count++;
      end
      if (resync) resync_seen++;
    end
  end

  int rs_at, st_at, sel;
  logic [31:0] d;
  logic [127:0] c;

  initial begin
    reset = 1'b1; start = 1'b0; fft_valid = 1'b0; fft_first = 1'b0;
    fft_data = '0; coefficients = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 32'h0, '0);
    checking = 1'b1;
    step(1, 0, 1, 1, 32'h1234_5678, '0);
    idle(3);

    // Flat symbols, no attenuation
    for (int k = 0; k < 64; k++) begin sym_a[k] = 32'h0100_FF00; sym_b[k] = 32'h0100_FF00; end
    out_count = 0;
    run_pair(1, '0, 0);
    chk("flat_bin1", got[1], 32'h0100_FF00);
    chk("flat_bin2", got[2], 32'hFF00_0100);
    chk("flat_bin0", got[0], 32'h0000_0000);
    chk("flat_count", 32'(out_count), 32'd64);
    $display("[tb] flat symbols: %0d outputs", out_count);

    // Bin 5 divided by 8 at TX
    for (int k = 0; k < 64; k++) begin sym_a[k] = '0; sym_b[k] = '0; end
    sym_a[5] = 32'h0800_0000; sym_b[5] = 32'h0800_0000;
    run_pair(1, 128'h1 << 10, 20);
    chk("div8_bin5", got[5], 32'h4000_0000);
    sym_a[5] = 32'h1000_0000; sym_b[5] = 32'h1000_0000;
    run_pair(1, 128'h1 << 10, 20);
    chk("div8_sat_bin5", got[5], 32'h7FFF_0000);
    $display("[tb] bin5 scaling: 0x4000 and saturated cases");

    // Averaging rounding and full-scale imaginary
    sym_a[1] = 32'h0003_7FFF; sym_b[1] = 32'h0004_7FFF;
    sym_a[5] = 32'hFFFD_7FFF; sym_b[5] = 32'hFFFC_7FFF;
    run_pair(1, '0, 30);
    chk("avg_pos", got[1], 32'h0003_7FFF);
    chk("avg_neg", got[5], 32'hFFFC_7FFF);
    $display("[tb] averaging: bin1 %h bin5 %h", got[1], got[5]);

    // Misplaced symbol marker at first-symbol index 20
    for (int k = 0; k < 64; k++) begin sym_a[k] = $urandom; sym_b[k] = $urandom; end
    step(0, 1, 0, 0, 32'h0, rc());
    for (int i = 0; i < 20; i++) step(0, 0, 1, i == 0, $urandom, rc());
    out_count = 0; resync_seen = 0;
    run_pair(0, '0, 10);
    chk("resync_pulses", 32'(resync_seen), 32'd1);
    chk("resync_outputs", 32'(out_count), 32'd64);
    $display("[tb] resync at index 20: %0d outputs", out_count);

    // Restart in the middle of the second symbol
    c = rc();
    step(0, 1, 0, 0, 32'h0, c);
    for (int i = 0; i < 94; i++) step(0, 0, 1, (i % 64) == 0, $urandom, rc());
    step(0, 1, 1, 0, $urandom, c);
    chk("busy_after_restart", {31'b0, busy}, 32'd1);
    out_count = 0;
    run_pair(0, '0, 15);
    chk("restart_outputs", 32'(out_count), 32'd64);
    $display("[tb] restart mid second symbol: %0d outputs", out_count);

    // Reset while collecting, then input must be ignored until start
    step(0, 1, 0, 0, 32'h0, rc());
    for (int i = 0; i < 30; i++) step(0, 0, 1, i == 0, $urandom, rc());
    step(1, 0, 1, 0, $urandom, rc());
    out_count = 0;
    for (int i = 0; i < 10; i++) step(0, 0, i % 2, 1, $urandom, rc());
    chk("busy_after_reset", {31'b0, busy}, 32'd0);
    chk("reset_outputs", 32'(out_count), 32'd0);
    run_pair(1, rc(), 10);
    $display("[tb] reset mid first symbol, recovered");

    // Random traffic with occasional resyncs and restarts
    for (int it = 0; it < 25; it++) begin
      c = rc();
      rs_at = ($urandom_range(3) == 0) ? int'($urandom_range(127, 1)) : -1;
      st_at = ($urandom_range(7) == 0) ? int'($urandom_range(127, 1)) : -1;
      out_count = 0;
      step(0, 1, 0, 0, 32'h0, c);
      for (int i = 0; i < 128; i++) begin
        while ($urandom_range(99) < 25) step(0, 0, 0, $urandom_range(1), $urandom, rc());
        sel = int'($urandom_range(2));
        d = $urandom;
        if (sel == 1) d = {{5{d[31]}}, d[26:16], {5{d[15]}}, d[10:0]};
        if (sel == 2) d = {d[31] ? 16'h8000 : 16'h7FFF, d[15] ? 16'h8000 : 16'h7FFF};
        step(0, i == st_at, 1, ((i % 64) == 0) || (i == rs_at), d, rc());
      end
      idle(4);
      $display("[tb] random run %0d: resync_at=%0d start_at=%0d outputs=%0d", it, rs_at, st_at, out_count);
    end

    idle(3);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
